// File: rtl/dot_matrix_scanner.sv
// dot_matrix_scanner
// Drives a ROWS x COLS LED matrix. It scans one row per dwell period with all
// column data for that row in parallel. Brightness is set by PWM within each
// dwell. The frame is double-buffered: the host writes a shadow copy, and the
// active copy swaps at a frame boundary, or on any cycle while scanning is
// disabled.
module dot_matrix_scanner #(
    parameter int ROWS     = 8,
    parameter int COLS     = 8,
    parameter int DIV      = 16,
    parameter int PWM_BITS = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [ROWS*COLS-1:0] frame_d,
    input  logic                 frame_we,
    input  logic [PWM_BITS-1:0]  brightness,
    input  logic                 enable,
    output logic [ROWS-1:0]      row_q,
    output logic [COLS-1:0]      col_q,
    output logic                 frame_start,
    output logic                 pending
);

    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int ROW_W = $clog2(ROWS);

    localparam logic [DIV_W-1:0]    DIV_MAX = DIV_W'(DIV - 1);
    localparam logic [ROW_W-1:0]    ROW_MAX = ROW_W'(ROWS - 1);
    localparam logic [PWM_BITS-1:0] PWM_MAX = '1;

    // Row-major frame view: frame[r][c] is flat bit r*COLS+c.
    typedef logic [ROWS-1:0][COLS-1:0] frame_t;

    // Scan position
    logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [ROW_W-1:0]    row_idx_q, row_idx_d;

    // Frame buffers and latched brightness
    frame_t              active_q, active_d;
    frame_t              shadow_q, shadow_d;
    logic                pending_q, pending_d;
    logic [PWM_BITS-1:0] bright_q, bright_d;

    // Registered output next-state
    logic [ROWS-1:0]     row_d;
    logic [COLS-1:0]     col_d;
    logic                frame_start_d;

    // Scan events
    logic                tick;
    logic                pwm_wrap;
    logic                boundary;
    logic                swap;
    logic                lit;

    // Next-state for the scan counters, frame buffers and latched brightness.
    always_comb begin
        // NOTE: every signal gets a default first, so no path through the
        // block leaves a value unassigned and no latch is inferred.
        div_cnt_d = div_cnt_q;
        pwm_cnt_d = pwm_cnt_q;
        row_idx_d = row_idx_q;
        active_d  = active_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        bright_d  = bright_q;

        tick     = (div_cnt_q == DIV_MAX);
        pwm_wrap = tick && (pwm_cnt_q == PWM_MAX);
        boundary = enable && pwm_wrap && (row_idx_q == ROW_MAX);

        // While disabled, every cycle acts as a boundary so a queued frame
        // is not left waiting.
        swap = !enable || boundary;

        if (!enable) begin
            div_cnt_d = '0;
            pwm_cnt_d = '0;
            row_idx_d = '0;
        end else begin
            div_cnt_d = tick ? '0 : div_cnt_q + DIV_W'(1);
            if (tick) begin
                pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
            end
            if (pwm_wrap) begin
                row_idx_d = (row_idx_q == ROW_MAX) ? '0 : row_idx_q + ROW_W'(1);
            end
        end

        if (swap) begin
            bright_d = brightness;
            if (pending_q) begin
                active_d  = shadow_q;
                pending_d = 1'b0;
            end
        end

        // A write on the swap edge lands in the shadow after the old shadow
        // has moved to active, so the new frame stays pending.
        if (frame_we) begin
            shadow_d  = frame_d;
            pending_d = 1'b1;
        end
    end

    // Output next-state, computed from the current scan position and active frame.
    always_comb begin
        lit           = enable && (pwm_cnt_q <= bright_q);
        row_d         = lit ? (ROWS'(1) << row_idx_q) : '0;
        col_d         = lit ? active_q[row_idx_q] : '0;
        frame_start_d = enable && (div_cnt_q == '0) && (pwm_cnt_q == '0)
                        && (row_idx_q == '0);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q   <= '0;
            pwm_cnt_q   <= '0;
            row_idx_q   <= '0;
            // NOTE: the frame buffers are flops, not RAM, so they are cleared
            // on reset. This keeps a blank frame on screen until the host writes.
            active_q    <= '0;
            shadow_q    <= '0;
            pending_q   <= 1'b0;
            bright_q    <= '0;
            row_q       <= '0;
            col_q       <= '0;
            frame_start <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments, so every register samples the
            // pre-edge values regardless of statement order.
            div_cnt_q   <= div_cnt_d;
            pwm_cnt_q   <= pwm_cnt_d;
            row_idx_q   <= row_idx_d;
            active_q    <= active_d;
            shadow_q    <= shadow_d;
            pending_q   <= pending_d;
            bright_q    <= bright_d;
            row_q       <= row_d;
            col_q       <= col_d;
            frame_start <= frame_start_d;
        end
    end

    assign pending = pending_q;

endmodule
